bf2_sdf: RTL

BF2_SDF -- requirements
Module: bf2_sdf

---
 rtl/bf2_sdf_if.sv | 27 ++
 rtl/bf2_sdf.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bf2_sdf_if.sv
// Stream bundle for the radix-2 SDF butterfly stage: sample input, result
// output, flush request and both ready/valid handshakes.
interface bf2_sdf_if #(
  parameter int DWIDTH = 32,
  parameter int OWIDTH = 32
);
  logic [DWIDTH-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic              i_flush;
  logic [OWIDTH-1:0] o_data;
  logic              o_valid;
  logic              o_sop;
  logic              i_ready;

  // Source/sink side driving samples in and consuming results.
  modport master (
    output i_data, i_valid, i_flush, i_ready,
    input  o_ready, o_data, o_valid, o_sop
  );

  // Butterfly side.
  modport slave (
    input  i_data, i_valid, i_flush, i_ready,
    output o_ready, o_data, o_valid, o_sop
  );
endinterface

// File: rtl/bf2_sdf.sv
// Radix-2 single-path delay-feedback butterfly (BF2I, or BF2II with a
// trivial -j rotation on alternate frames). First half of a frame is parked
// in the delay line; the second half emits sums and parks differences,
// which drain while the next frame fills or on an explicit flush.
module bf2_sdf #(
  parameter int DWIDTH    = 32,
  parameter int DEPTH_LOG = 3,
  parameter int MODE      = 0,
  parameter int SCALE     = 1
) (
  input  logic      clk,
  input  logic      reset_n,
  bf2_sdf_if.slave  bus
);
  localparam int HW     = DWIDTH / 2;
  localparam int OHW    = (SCALE != 0) ? HW : HW + 1;
  localparam int OWIDTH = 2 * OHW;
  localparam int AW     = HW + 2;
  localparam int N      = 1 << DEPTH_LOG;
  localparam int CW     = (DEPTH_LOG > 0) ? DEPTH_LOG : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [2:0] {FILL, CALC, PEND, OVLP, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              t_q, t_d;
  logic              o_valid_q, o_valid_d;
  logic              o_sop_q, o_sop_d;
  logic [OWIDTH-1:0] o_data_q, o_data_d;

  logic [OWIDTH-1:0] line_q [N];
  logic              line_we;
  logic [OWIDTH-1:0] line_wdata;

  logic              o_ready_c;
  logic              ld_ok;
  logic              cnt_wrap;
  logic [CW-1:0]     cnt_next;

  logic [OWIDTH-1:0]     a_ent;
  logic signed [OHW-1:0] a_re, a_im;
  logic signed [HW-1:0]  x_re, x_im;
  logic signed [AW-1:0]  ar, ai, br, bi, sr, si, dr, di;
  logic                  rot;
  logic [OWIDTH-1:0]     sum_pk, dif_pk, in_ext;

  // Butterfly datapath: widen to HW+2 so the rotated -(-2^(HW-1)) and the
  // add/sub never wrap, then scale or keep full growth.
  always_comb begin
    a_ent = line_q[cnt_q];
    a_re  = a_ent[OWIDTH-1:OHW];
    a_im  = a_ent[OHW-1:0];
    x_re  = bus.i_data[DWIDTH-1:HW];
    x_im  = bus.i_data[HW-1:0];
    rot   = (MODE != 0) && t_q;
    ar    = AW'(a_re);
    ai    = AW'(a_im);
    if (rot) begin
      br = AW'(x_im);
      bi = -AW'(x_re);
    end else begin
      br = AW'(x_re);
      bi = AW'(x_im);
    end
    sr = ar + br;
    si = ai + bi;
    dr = ar - br;
    di = ai - bi;
    if (SCALE != 0) begin
      sum_pk = {OHW'(sr >>> 1), OHW'(si >>> 1)};
      dif_pk = {OHW'(dr >>> 1), OHW'(di >>> 1)};
    end else begin
      sum_pk = {OHW'(sr), OHW'(si)};
      dif_pk = {OHW'(dr), OHW'(di)};
    end
    in_ext = {OHW'(x_re), OHW'(x_im)};
  end

  // Frame sequencing, handshakes and output-register load decisions.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    t_d        = t_q;
    ld_ok      = !o_valid_q || bus.i_ready;
    o_valid_d  = o_valid_q && !bus.i_ready;
    o_data_d   = o_data_q;
    o_sop_d    = ld_ok ? 1'b0 : o_sop_q;
    line_we    = 1'b0;
    line_wdata = in_ext;
    o_ready_c  = 1'b0;
    cnt_wrap   = (cnt_q == CNT_LAST);
    cnt_next   = cnt_wrap ? '0 : cnt_q + 1'b1;

    case (state_q)
      FILL: begin
        o_ready_c = 1'b1;
        if (bus.i_valid) begin
          line_we = 1'b1;
          cnt_d   = cnt_next;
          if (cnt_wrap) state_d = CALC;
        end
      end
      CALC: begin
        o_ready_c = ld_ok;
        if (bus.i_valid && ld_ok) begin
          o_valid_d  = 1'b1;
          o_data_d   = sum_pk;
          o_sop_d    = (cnt_q == '0);
          line_we    = 1'b1;
          line_wdata = dif_pk;
          cnt_d      = cnt_next;
          if (cnt_wrap) begin
            state_d = PEND;
            if (MODE != 0) t_d = !t_q;
          end
        end
      end
      // PEND shares the overlap datapath: an accepted sample there both
      // emits a pending difference and starts the next frame.
      PEND, OVLP: begin
        o_ready_c = ld_ok && !((state_q == PEND) && bus.i_flush);
        if (bus.i_valid && o_ready_c) begin
          o_valid_d = 1'b1;
          o_data_d  = a_ent;
          o_sop_d   = 1'b0;
          line_we   = 1'b1;
          cnt_d     = cnt_next;
          state_d   = cnt_wrap ? CALC : OVLP;
        end else if ((state_q == PEND) && bus.i_flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ld_ok) begin
          o_valid_d = 1'b1;
          o_data_d  = a_ent;
          o_sop_d   = 1'b0;
          cnt_d     = cnt_next;
          if (cnt_wrap) state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Control state and output register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      t_q       <= 1'b0;
      o_valid_q <= 1'b0;
      o_sop_q   <= 1'b0;
      o_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      t_q       <= t_d;
      o_valid_q <= o_valid_d;
      o_sop_q   <= o_sop_d;
      o_data_q  <= o_data_d;
    end
  end

  // Delay line storage; entries are always written before they are read.
  always_ff @(posedge clk) begin
    if (line_we) line_q[cnt_q] <= line_wdata;
  end

  assign bus.o_ready = o_ready_c;
  assign bus.o_valid = o_valid_q;
  assign bus.o_sop   = o_sop_q;
  assign bus.o_data  = o_data_q;
endmodule
